// File: rtl/mult_pkg.sv
// Shared types and constants for the multiplier's BCD/binary conversion paths.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CONV, DONE} b2b_state_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ       = 4'd3;

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Reverse double-dabble digit correction: subtract 3 from a nibble that is >= 8.
module bcd_nibble_adjust
  import mult_pkg::*;
(
  input  logic [3:0] nib,
  output logic [3:0] adj
);

  // nib >= 8 is exactly nib[3]; the subtraction can never underflow.
  always_comb begin
    adj = nib;
    if (nib[3]) adj = nib - BCD_ADJ;
  end

endmodule

// File: rtl/bcd_binary.sv
// Sequential BCD-to-binary converter: one reverse double-dabble shift/adjust per clock.
module bcd_binary
  import mult_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  b2b_state_t        state, state_nxt;
  logic [SR_W-1:0]   sr, sr_nxt, sr_shift, sr_adj;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err_r, err_nxt;
  logic              bad_digit;

  assign sr_shift = sr >> 1;
  assign sr_adj[BIN_W-1:0] = sr_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .nib (sr_shift[BIN_W+4*g +: 4]),
      .adj (sr_adj[BIN_W+4*g +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_DIGIT_MAX) bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      err_r <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      err_r <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    err_nxt   = err_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          // Binary field loads as zero, so an illegal operand already reads back 0.
          sr_nxt  = {bcd_in, {BIN_W{1'b0}}};
          cnt_nxt = '0;
          err_nxt = bad_digit;
          state_nxt = bad_digit ? DONE : CONV;
        end
      end
      CONV: begin
        sr_nxt  = sr_adj;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(BIN_W - 1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bin_out   = sr[BIN_W-1:0];
  assign err       = err_r;

endmodule

// File: tb/tb_bcd_binary.sv
// Directed bench for bcd_binary: default 4-digit instance plus a 3-digit/10-bit instance.
module tb_bcd_binary;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bcd_in;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [13:0] bin_out;

  logic [11:0] bcd_in2;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, err2;
  logic [9:0]  bin_out2;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  bcd_binary #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
    .bin_out(bin_out), .err(err), .out_valid(out_valid), .out_ready(out_ready)
  );

  bcd_binary #(.DIGITS(3), .BIN_W(10)) dut2 (
    .clk(clk), .reset(reset), .bcd_in(bcd_in2), .in_valid(in_valid2), .in_ready(in_ready2),
    .bin_out(bin_out2), .err(err2), .out_valid(out_valid2), .out_ready(out_ready2)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [13:0] exp_bin;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Edges counted from the accept edge (inclusive) until out_valid is seen high.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept(input logic [15:0] bcd);
    @(negedge clk);
    bcd_in   = bcd;
    in_valid = 1'b1;
    chk("in_ready_before_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_handshake(input string name);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_out_valid_drop"}, out_valid, 0);
    chk({name, "_in_ready_back"}, in_ready, 1);
  endtask

  task automatic run_op(input vec_t v, input string name);
    int lat;
    accept(v.bcd);
    wait_result(lat);
    chk({name, "_latency"}, lat, v.exp_lat);
    chk({name, "_bin"}, bin_out, v.exp_bin);
    chk({name, "_err"}, err, v.exp_err);
    finish_handshake(name);
  endtask

  task automatic run_op2(input logic [11:0] bcd, input logic [9:0] exp_bin, input string name);
    int lat;
    @(negedge clk);
    bcd_in2   = bcd;
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    lat = 1;
    while (!out_valid2 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, 11);
    chk({name, "_bin"}, bin_out2, exp_bin);
    chk({name, "_err"}, err2, 0);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    chk({name, "_in_ready_back"}, in_ready2, 1);
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0] = '{16'h0000, 14'd0,    1'b0, 15};
    vecs[1] = '{16'h9999, 14'd9999, 1'b0, 15};
    vecs[2] = '{16'h1A07, 14'd0,    1'b1, 1};
    vecs[3] = '{16'h0042, 14'd42,   1'b0, 15};
    vecs[4] = '{16'h0001, 14'd1,    1'b0, 15};
    vecs[5] = '{16'h8000, 14'd8000, 1'b0, 15};
    vecs[6] = '{16'h000F, 14'd0,    1'b1, 1};
    vecs[7] = '{16'h1234, 14'd1234, 1'b0, 15};

    reset = 1'b1;
    bcd_in = '0;  in_valid = 1'b0;  out_ready = 1'b0;
    bcd_in2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_bin_out", bin_out, 0);
    chk("reset_err", err, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Held output while a new operand waits at the input.
    accept(16'h0123);
    wait_result(lat);
    chk("hold_first_latency", lat, 15);
    bcd_in   = 16'h4096;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("hold_bin_stable", bin_out, 123);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_out_valid_drop", out_valid, 0);
    chk("b2b_in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_second_accepted", in_ready, 0);
    wait_result(lat);
    chk("b2b_second_latency", lat, 15);
    chk("b2b_second_bin", bin_out, 4096);
    chk("b2b_second_err", err, 0);
    finish_handshake("b2b");

    // Reset during the sixth conversion cycle.
    accept(16'h5555);
    repeat (5) @(negedge clk);
    chk("midreset_in_conv", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midreset_no_result", seen, 0);
    run_op('{16'h0007, 14'd7, 1'b0, 15}, "after_reset");

    run_op2(12'h999, 10'd999, "d3_999");
    run_op2(12'h512, 10'd512, "d3_512");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
